exc_ctrl: RTL and testbench

- Exception/interrupt sequencer sitting directly upstream of the CP0 register file. It takes exception reports from the MEM stage and the current CP0 Status/Cause/EPC.
- Arbitrates interrupts, exceptions and ERET, then drives the CP0 single write port over several cycles: EPC, then Status, then Cause.
- Flushes the pipeline and issues the redirect PC.

---
 rtl/exc_ctrl.sv | 150 +++++++++++++++
 tb/tb_exc_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer in front of the CP0 register file.
// It arbitrates events in IDLE, then writes EPC/Status/Cause over several cycles and redirects the PC.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_code_i,
  input  logic        eret_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_bd_i,
  input  logic        mem_valid_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        cp0_we_o,
  output logic [4:0]  cp0_waddr_o,
  output logic [31:0] cp0_wdata_o,
  output logic        flush_o,
  output logic        new_pc_valid_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, WR_EPC, WR_STATUS, WR_CAUSE, REDIRECT, ERET_ST, ERET_RD
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic        bd_reg, bd_next;
  logic [4:0]  code_reg, code_next;
  logic [31:0] status_reg, status_next;
  // Only the Cause bits that survive into the rewritten Cause are kept.
  logic [25:0] cause_reg, cause_next;

  logic        we_next, npv_next;
  logic [4:0]  waddr_next;
  logic [31:0] wdata_next, npc_next;
  logic        int_pending;

  assign int_pending = mem_valid_i & cp0_status_i[0] & ~cp0_status_i[1]
                     & (|(cp0_status_i[15:8] & cp0_cause_i[15:8]));

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    bd_next     = bd_reg;
    code_next   = code_reg;
    status_next = status_reg;
    cause_next  = cause_reg;
    case (state_reg)
      IDLE: begin
        if (int_pending || exc_valid_i || eret_i) begin
          pc_next     = mem_pc_i;
          bd_next     = mem_bd_i;
          status_next = cp0_status_i;
          cause_next  = {cp0_cause_i[30:7], cp0_cause_i[1:0]};
          code_next   = int_pending ? 5'd0 : exc_code_i;
          if (int_pending || exc_valid_i)
            // A nested exception keeps the EPC of the outer one.
            state_next = cp0_status_i[1] ? WR_STATUS : WR_EPC;
          else
            state_next = ERET_ST;
        end
      end
      WR_EPC:    state_next = WR_STATUS;
      WR_STATUS: state_next = WR_CAUSE;
      WR_CAUSE:  state_next = REDIRECT;
      REDIRECT:  state_next = IDLE;
      ERET_ST:   state_next = ERET_RD;
      ERET_RD:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register alongside it.
  always_comb begin
    we_next    = 1'b0;
    waddr_next = 5'd0;
    wdata_next = 32'd0;
    npv_next   = 1'b0;
    npc_next   = 32'd0;
    case (state_next)
      WR_EPC: begin
        we_next    = 1'b1;
        waddr_next = 5'd14;
        wdata_next = bd_next ? (pc_next - 32'd4) : pc_next;
      end
      WR_STATUS: begin
        we_next    = 1'b1;
        waddr_next = 5'd12;
        wdata_next = status_next | 32'h2;
      end
      WR_CAUSE: begin
        we_next    = 1'b1;
        waddr_next = 5'd13;
        wdata_next = {bd_next, cause_next[25:2], code_next, cause_next[1:0]};
      end
      ERET_ST: begin
        we_next    = 1'b1;
        waddr_next = 5'd12;
        wdata_next = status_next & ~32'h2;
      end
      REDIRECT: begin
        npv_next = 1'b1;
        npc_next = EXC_VECTOR;
      end
      ERET_RD: begin
        npv_next = 1'b1;
        npc_next = cp0_epc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      pc_reg         <= '0;
      bd_reg         <= 1'b0;
      code_reg       <= '0;
      status_reg     <= '0;
      cause_reg      <= '0;
      cp0_we_o       <= 1'b0;
      cp0_waddr_o    <= '0;
      cp0_wdata_o    <= '0;
      flush_o        <= 1'b0;
      new_pc_valid_o <= 1'b0;
      new_pc_o       <= '0;
      busy_o         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      bd_reg         <= bd_next;
      code_reg       <= code_next;
      status_reg     <= status_next;
      cause_reg      <= cause_next;
      cp0_we_o       <= we_next;
      cp0_waddr_o    <= waddr_next;
      cp0_wdata_o    <= wdata_next;
      flush_o        <= (state_next != IDLE);
      new_pc_valid_o <= npv_next;
      new_pc_o       <= npc_next;
      busy_o         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: each scenario queues the expected per-cycle outputs
// when it drives the event, then pops and compares one entry per cycle.
module tb_exc_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc_valid_i = 1'b0;
  logic [4:0]  exc_code_i = '0;
  logic        eret_i = 1'b0;
  logic [31:0] mem_pc_i = '0;
  logic        mem_bd_i = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] cp0_status_i = '0;
  logic [31:0] cp0_cause_i = '0;
  logic [31:0] cp0_epc_i = '0;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        flush_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  always #5 clk = ~clk;

  exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
    .clk(clk), .rst(rst),
    .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .eret_i(eret_i),
    .mem_pc_i(mem_pc_i), .mem_bd_i(mem_bd_i), .mem_valid_i(mem_valid_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i), .cp0_epc_i(cp0_epc_i),
    .cp0_we_o(cp0_we_o), .cp0_waddr_o(cp0_waddr_o), .cp0_wdata_o(cp0_wdata_o),
    .flush_o(flush_o), .new_pc_valid_o(new_pc_valid_o), .new_pc_o(new_pc_o),
    .busy_o(busy_o)
  );

  // {busy, flush, we, waddr, wdata, new_pc_valid, new_pc}
  typedef logic [72:0] obs_t;
  obs_t obs;
  assign obs = {busy_o, flush_o, cp0_we_o, cp0_waddr_o, cp0_wdata_o, new_pc_valid_o, new_pc_o};

  obs_t exp_q[$];
  obs_t e;
  int compared = 0;
  int mismatched = 0;

  function automatic obs_t wr(input logic [4:0] addr, input logic [31:0] data);
    return {1'b1, 1'b1, 1'b1, addr, data, 1'b0, 32'd0};
  endfunction

  function automatic obs_t rd(input logic [31:0] pc);
    return {1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1, pc};
  endfunction

  function automatic obs_t idle();
    return '0;
  endfunction

  task automatic drive(input logic ev, input logic er, input logic mv, input logic [4:0] code,
                       input logic [31:0] pc, input logic bd, input logic [31:0] st,
                       input logic [31:0] ca, input logic [31:0] epc);
    exc_valid_i  = ev;
    eret_i       = er;
    mem_valid_i  = mv;
    exc_code_i   = code;
    mem_pc_i     = pc;
    mem_bd_i     = bd;
    cp0_status_i = st;
    cp0_cause_i  = ca;
    cp0_epc_i    = epc;
  endtask

  task automatic clear_events();
    exc_valid_i = 1'b0;
    eret_i      = 1'b0;
    mem_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    compared++;
    if (obs !== idle()) begin
      mismatched++;
      $display("FAIL reset_async: got %h want %h", obs, idle());
    end else $display("reset_async obs=%h", obs);
    @(negedge clk);
    compared++;
    if (obs !== idle()) begin
      mismatched++;
      $display("FAIL reset_held: got %h want %h", obs, idle());
    end else $display("reset_held obs=%h", obs);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (obs !== idle()) begin
      mismatched++;
      $display("FAIL reset_idle: got %h want %h", obs, idle());
    end else $display("reset_idle obs=%h", obs);
  endtask

  task automatic test_overflow();
    drive(1, 0, 1, 5'd12, 32'h0000_0104, 0, 32'h1000_0001, 32'h0, 32'h0);
    exp_q.push_back(wr(14, 32'h0000_0104));
    exp_q.push_back(wr(12, 32'h1000_0003));
    exp_q.push_back(wr(13, 32'h0000_0030));
    exp_q.push_back(rd(32'h0000_0020));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL overflow cyc%0d: got %h want %h", i, obs, e);
      end else $display("overflow cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  task automatic test_delay_slot();
    drive(1, 0, 1, 5'd8, 32'h0000_0200, 1, 32'h1000_0001, 32'h0, 32'h0);
    exp_q.push_back(wr(14, 32'h0000_01FC));
    exp_q.push_back(wr(12, 32'h1000_0003));
    exp_q.push_back(wr(13, 32'h8000_0020));
    exp_q.push_back(rd(32'h0000_0020));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL delay_slot cyc%0d: got %h want %h", i, obs, e);
      end else $display("delay_slot cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  task automatic test_nested();
    drive(1, 0, 1, 5'd10, 32'h0000_0240, 0, 32'h1000_0003, 32'h0, 32'h0);
    exp_q.push_back(wr(12, 32'h1000_0003));
    exp_q.push_back(wr(13, 32'h0000_0028));
    exp_q.push_back(rd(32'h0000_0020));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL nested cyc%0d: got %h want %h", i, obs, e);
      end else $display("nested cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  // Case 0: interrupt wins; 1: IE=0; 2: mem_valid=0 suppresses the interrupt.
  task automatic test_interrupt();
    logic [31:0] st;
    logic        mv;
    for (int c = 0; c < 3; c++) begin
      st = (c == 1) ? 32'h1000_8000 : 32'h1000_8001;
      mv = (c == 2) ? 1'b0 : 1'b1;
      drive(1, 0, mv, 5'd12, 32'h0000_0400, 0, st, 32'h0000_8000, 32'h0);
      exp_q.push_back(wr(14, 32'h0000_0400));
      exp_q.push_back(wr(12, st | 32'h2));
      exp_q.push_back(wr(13, (c == 0) ? 32'h0000_8000 : 32'h0000_8030));
      exp_q.push_back(rd(32'h0000_0020));
      exp_q.push_back(idle());
      for (int i = 0; exp_q.size() > 0; i++) begin
        @(negedge clk);
        e = exp_q.pop_front();
        compared++;
        if (obs !== e) begin
          mismatched++;
          $display("FAIL interrupt case%0d cyc%0d: got %h want %h", c, i, obs, e);
        end else $display("interrupt case%0d cyc%0d obs=%h", c, i, obs);
        if (i == 0) clear_events();
      end
    end
  endtask

  task automatic test_eret();
    drive(0, 1, 1, 5'd0, 32'h0000_0500, 0, 32'h1000_0003, 32'h0, 32'h0000_0300);
    exp_q.push_back(wr(12, 32'h1000_0001));
    exp_q.push_back(rd(32'h0000_0300));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL eret cyc%0d: got %h want %h", i, obs, e);
      end else $display("eret cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  task automatic test_eret_with_exc();
    drive(1, 1, 1, 5'd9, 32'h0000_0500, 0, 32'h1000_0001, 32'h0, 32'h0000_0300);
    exp_q.push_back(wr(14, 32'h0000_0500));
    exp_q.push_back(wr(12, 32'h1000_0003));
    exp_q.push_back(wr(13, 32'h0000_0024));
    exp_q.push_back(rd(32'h0000_0020));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL eret_exc cyc%0d: got %h want %h", i, obs, e);
      end else $display("eret_exc cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  // Exception, then an ERET held from the REDIRECT cycle into the following IDLE cycle.
  task automatic test_back_to_back();
    drive(1, 0, 1, 5'd12, 32'h0000_0600, 0, 32'h1000_0001, 32'h0, 32'h0000_0700);
    exp_q.push_back(wr(14, 32'h0000_0600));
    exp_q.push_back(wr(12, 32'h1000_0003));
    exp_q.push_back(wr(13, 32'h0000_0030));
    exp_q.push_back(rd(32'h0000_0020));
    exp_q.push_back(idle());
    exp_q.push_back(wr(12, 32'h1000_0001));
    exp_q.push_back(rd(32'h0000_0700));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL back_to_back cyc%0d: got %h want %h", i, obs, e);
      end else $display("back_to_back cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
      if (i == 3) begin
        eret_i       = 1'b1;
        mem_valid_i  = 1'b1;
        cp0_status_i = 32'h1000_0003;
      end
      if (i == 5) clear_events();
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 0, 1, 5'd12, 32'h0000_0800, 0, 32'h1000_0001, 32'h0, 32'h0000_0900);
    exp_q.push_back(wr(14, 32'h0000_0800));
    exp_q.push_back(wr(12, 32'h1000_0003));
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, obs, e);
      end else $display("reset_mid cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if (obs !== idle()) begin
      mismatched++;
      $display("FAIL reset_mid_async: got %h want %h", obs, idle());
    end else $display("reset_mid_async obs=%h", obs);
    @(negedge clk);
    compared++;
    if (obs !== idle()) begin
      mismatched++;
      $display("FAIL reset_mid_no_cause: got %h want %h", obs, idle());
    end else $display("reset_mid_no_cause obs=%h", obs);
    rst = 1'b1;
    drive(0, 1, 1, 5'd0, 32'h0000_0800, 0, 32'h1000_0003, 32'h0, 32'h0000_0900);
    exp_q.push_back(wr(12, 32'h1000_0001));
    exp_q.push_back(rd(32'h0000_0900));
    exp_q.push_back(idle());
    for (int i = 0; exp_q.size() > 0; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL reset_recover cyc%0d: got %h want %h", i, obs, e);
      end else $display("reset_recover cyc%0d obs=%h", i, obs);
      if (i == 0) clear_events();
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_delay_slot();
    test_nested();
    test_interrupt();
    test_eret();
    test_eret_with_exc();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
